grp1_exec: RTL

GRP1_EXEC -- requirements
Module: grp1_exec

---
 rtl/grp1_exec.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/grp1_exec.sv
// grp1_exec: multi-cycle executor for the 6502 group-one opcodes (cc=01):
// ORA, AND, EOR, ADC, STA, LDA, CMP, SBC over all eight addressing modes.
// X and Y are supplied from outside; A and the flags live here.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   d_in      memory read data, sampled at the edge closing each read cycle
//   rdy       0 stalls read cycles (STA write cycles always complete)
//   x_in      X index value
//   y_in      Y index value
//   dec_mode  decimal flag (only honoured when DECIMAL_EN=1)
//   addr      memory address
//   d_out     write data (0 when not writing)
//   we        write strobe
//   sync      high during opcode fetch
//   a_out     accumulator
//   p_out     status {N,V,1,0,D,0,Z,C}
//   illegal   one-cycle pulse for an opcode outside group one
//   state_o   current FSM state (debug)
//
// Bus handshake: a cycle is a read cycle in every state except EXEC of STA.
// A read cycle completes at the rising edge where rdy=1; while rdy=0 every
// register holds and addr stays put. The STA write cycle ignores rdy.
module grp1_exec #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          DECIMAL_EN = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  d_in,
  input  logic        rdy,
  input  logic [7:0]  x_in,
  input  logic [7:0]  y_in,
  input  logic        dec_mode,
  output logic [15:0] addr,
  output logic [7:0]  d_out,
  output logic        we,
  output logic        sync,
  output logic [7:0]  a_out,
  output logic [7:0]  p_out,
  output logic        illegal,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    OPND  = 3'd1,
    ABS_H = 3'd2,
    IDX   = 3'd3,
    PTR_L = 3'd4,
    PTR_H = 3'd5,
    EXEC  = 3'd6
  } state_t;

  localparam logic DEC_OK = (DECIMAL_EN != 0);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [15:0] ea_q, ea_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  a_q, a_d;
  logic        n_q, n_d, v_q, v_d, z_q, z_d, c_q, c_d;

  logic        advance;
  logic        alu_en;
  logic        dec_on;
  logic [2:0]  aaa;
  logic [2:0]  mode;
  logic        ill;
  logic        is_sta;
  logic [7:0]  idx_val;

  assign aaa     = ir_q[7:5];
  assign mode    = ir_q[4:2];
  assign ill     = (ir_q[1:0] != 2'b01);
  assign is_sta  = (aaa == 3'b100);
  assign dec_on  = DEC_OK & dec_mode;
  // abs,Y and (zp),Y index with Y; every other indexed mode uses X
  assign idx_val = ((mode == 3'b110) || (mode == 3'b100)) ? y_in : x_in;

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ea_d    = ea_q;
    ptr_d   = ptr_q;
    addr    = pc_q;
    we      = 1'b0;
    d_out   = 8'h00;
    sync    = 1'b0;
    illegal = 1'b0;
    alu_en  = 1'b0;
    advance = rdy;

    case (state_q)
      FETCH: begin
        sync    = 1'b1;
        ir_d    = d_in;
        pc_d    = pc_q + 16'd1;
        state_d = OPND;
      end

      OPND: begin
        if (ill) begin
          // dummy read at PC, no operand consumed
          illegal = 1'b1;
          state_d = FETCH;
        end else begin
          pc_d  = pc_q + 16'd1;
          ea_d  = {8'h00, d_in};
          ptr_d = d_in;
          case (mode)
            3'b010: begin
              alu_en  = !is_sta;   // STA #imm is a NOP
              state_d = FETCH;
            end
            3'b001:                 state_d = EXEC;
            3'b101, 3'b000:         state_d = IDX;
            3'b100:                 state_d = PTR_L;
            default:                state_d = ABS_H;
          endcase
        end
      end

      ABS_H: begin
        pc_d        = pc_q + 16'd1;
        ea_d[15:8]  = d_in;
        state_d     = (mode == 3'b011) ? EXEC : IDX;
      end

      IDX: begin
        // dummy read at the unindexed address while the index is applied
        addr = ea_q;
        case (mode)
          3'b101: begin
            ea_d    = {8'h00, ea_q[7:0] + x_in};
            state_d = EXEC;
          end
          3'b000: begin
            ptr_d   = ea_q[7:0] + x_in;
            state_d = PTR_L;
          end
          default: begin
            ea_d    = ea_q + {8'h00, idx_val};
            state_d = EXEC;
          end
        endcase
      end

      PTR_L: begin
        addr       = {8'h00, ptr_q};
        ea_d[7:0]  = d_in;
        state_d    = PTR_H;
      end

      PTR_H: begin
        // pointer high byte wraps inside page zero
        addr       = {8'h00, ptr_q + 8'd1};
        ea_d[15:8] = d_in;
        state_d    = (mode == 3'b000) ? EXEC : IDX;
      end

      EXEC: begin
        addr    = ea_q;
        state_d = FETCH;
        if (is_sta) begin
          we      = 1'b1;
          d_out   = a_q;
          advance = 1'b1;
        end else begin
          alu_en  = 1'b1;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  // ---------------------------------------------------------------------
  // ALU (operand is always d_in)
  // ---------------------------------------------------------------------
  logic [7:0] alu_a;
  logic       alu_n, alu_v, alu_z, alu_c;
  logic [7:0] mm;
  logic [8:0] bin;
  logic [8:0] cmp;
  logic [4:0] al, al_adj, ah, ah_adj;
  logic       lc, hc;
  logic [4:0] sl, sl_adj, sh, sh_adj;
  logic       bl;

  always_comb begin
    alu_a = a_q;
    alu_n = n_q;
    alu_v = v_q;
    alu_z = z_q;
    alu_c = c_q;

    // SBC is ADC with the operand inverted
    mm  = (aaa == 3'b111) ? ~d_in : d_in;
    bin = {1'b0, a_q} + {1'b0, mm} + {8'h00, c_q};
    cmp = {1'b0, a_q} - {1'b0, d_in};

    // decimal add: adjust each nibble that exceeds 9
    al     = {1'b0, a_q[3:0]} + {1'b0, d_in[3:0]} + {4'h0, c_q};
    lc     = (al > 5'd9);
    al_adj = lc ? al + 5'd6 : al;
    ah     = {1'b0, a_q[7:4]} + {1'b0, d_in[7:4]} + {4'h0, lc};
    hc     = (ah > 5'd9);
    ah_adj = hc ? ah + 5'd6 : ah;

    // decimal subtract: a borrowing nibble is corrected by -6
    sl     = {1'b0, a_q[3:0]} - {1'b0, d_in[3:0]} - {4'h0, ~c_q};
    bl     = sl[4];
    sl_adj = bl ? sl - 5'd6 : sl;
    sh     = {1'b0, a_q[7:4]} - {1'b0, d_in[7:4]} - {4'h0, bl};
    sh_adj = sh[4] ? sh - 5'd6 : sh;

    case (aaa)
      3'b000: alu_a = a_q | d_in;
      3'b001: alu_a = a_q & d_in;
      3'b010: alu_a = a_q ^ d_in;
      3'b101: alu_a = d_in;
      3'b011: begin
        alu_v = (a_q[7] == mm[7]) && (bin[7] != a_q[7]);
        if (dec_on) begin
          alu_a = {ah_adj[3:0], al_adj[3:0]};
          alu_c = hc;
        end else begin
          alu_a = bin[7:0];
          alu_c = bin[8];
        end
      end
      3'b111: begin
        alu_v = (a_q[7] == mm[7]) && (bin[7] != a_q[7]);
        alu_c = bin[8];
        alu_a = dec_on ? {sh_adj[3:0], sl_adj[3:0]} : bin[7:0];
      end
      default: ;
    endcase

    if (aaa == 3'b110) begin
      alu_c = ~cmp[8];
      alu_n = cmp[7];
      alu_z = (cmp[7:0] == 8'h00);
    end else begin
      alu_n = alu_a[7];
      alu_z = (alu_a == 8'h00);
    end
  end

  assign a_d = (alu_en && aaa != 3'b110) ? alu_a : a_q;
  assign n_d = alu_en ? alu_n : n_q;
  assign v_d = alu_en ? alu_v : v_q;
  assign z_d = alu_en ? alu_z : z_q;
  assign c_d = alu_en ? alu_c : c_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      ea_q    <= 16'h0000;
      ptr_q   <= 8'h00;
      a_q     <= 8'h00;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else if (advance) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ea_q    <= ea_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      n_q     <= n_d;
      v_q     <= v_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  assign a_out   = a_q;
  assign p_out   = {n_q, v_q, 1'b1, 1'b0, dec_on, 1'b0, z_q, c_q};
  assign state_o = state_q;

endmodule
